// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage: NOP filler, FSM states and
// the default (32-bit) queue entry layout.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          FETCH_XLEN = 32;

    typedef enum logic {
        HALT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with push, pop, count and a flush that beats
// both push and pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  entry_t                       push_data,
    input  logic                         pop,
    input  logic                         flush,
    output entry_t                       head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: registers update with <= so every term reads its pre-edge value.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; count alone says which slots hold data.
    always_ff @(posedge clk) begin
        if (do_push && reset && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: PC generation, credit-limited imem requests, in-order response
// capture into the prefetch queue, and redirect flush with response discard.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_en,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rsp_valid,
    input  logic [XLEN-1:0]  imem_rsp_data,
    output logic             valid_d,
    output logic [XLEN-1:0]  instr_d,
    output logic [XLEN-1:0]  pc_d,
    output logic [XLEN-1:0]  pc_plus4_d,
    input  logic             stall_d
);

    localparam int           CW      = $clog2(DEPTH+1);
    localparam logic [CW:0]  CREDITS = (CW+1)'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    fetch_state_t     state;
    logic [XLEN-1:0]  pc_f;
    logic [XLEN-1:0]  pc_rsp;
    logic [XLEN-1:0]  redirect_target;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    discard;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             accept;
    logic             rsp_live;
    logic             push;
    logic             pop;
    entry_t           head;
    entry_t           push_entry;

    assign redirect_target = redirect_pc & ~XLEN'(3);

    // Queued entries plus in-flight requests never exceed DEPTH, so every response has a slot.
    assign imem_req  = reset && (state == RUN) && !redirect_valid &&
                       (({1'b0, count} + {1'b0, outstanding}) < CREDITS);
    assign imem_addr = pc_f;
    assign accept    = imem_req && imem_ready;
    assign rsp_live  = imem_rsp_valid && (outstanding != '0);
    assign push      = rsp_live && (discard == '0) && !full;
    assign pop       = valid_d && !stall_d && !redirect_valid;

    assign push_entry = '{pc: pc_rsp, instr: imem_rsp_data};

    assign valid_d    = reset && !empty;
    assign instr_d    = valid_d ? head.instr : XLEN'(NOP_INSTR);
    assign pc_d       = valid_d ? head.pc : '0;
    assign pc_plus4_d = pc_d + XLEN'(4);

    fetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= HALT;
            pc_f        <= RESET_PC;
            pc_rsp      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            case (state)
                HALT: if (run_en)  state <= RUN;
                RUN:  if (!run_en) state <= HALT;
            endcase

            outstanding <= outstanding + CW'(accept) - CW'(rsp_live);

            // Everything still in flight after this cycle belongs to the old path.
            if (redirect_valid) begin
                pc_f    <= redirect_target;
                pc_rsp  <= redirect_target;
                discard <= outstanding - CW'(rsp_live);
            end else begin
                if (accept) pc_f   <= pc_f + XLEN'(4);
                if (push)   pc_rsp <= pc_rsp + XLEN'(4);
                if (rsp_live && (discard != '0)) discard <= discard - CW'(1);
            end
        end
    end

endmodule
